// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the multicycle shift sequencer:
// FSM states, shift-register command codes, constant-mux step codes,
// and the op-to-command and greedy step-selection functions.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'b000,
        CMD_LOAD = 3'b001,
        CMD_SLL  = 3'b010,
        CMD_SRL  = 3'b011,
        CMD_SRA  = 3'b100,
        CMD_ROR  = 3'b101
    } shift_cmd_t;

    // Encoding 2'b11 is reserved on the constant mux and is never produced.
    typedef enum logic [1:0] {
        STEP1 = 2'b00,
        STEP2 = 2'b01,
        STEP3 = 2'b10
    } step_sel_t;

    // Map the 2-bit shift kind onto the shift-register command.
    function automatic shift_cmd_t op_to_cmd(input logic [1:0] op);
        shift_cmd_t cmd;
        unique case (op)
            2'b00:   cmd = CMD_SLL;
            2'b01:   cmd = CMD_SRL;
            2'b10:   cmd = CMD_SRA;
            default: cmd = CMD_ROR;
        endcase
        return cmd;
    endfunction

    // Greedy step choice: 3 while at least 3 remain, then 2 or 1.
    function automatic step_sel_t select_step(input logic rem_ge3, input logic rem_is2);
        step_sel_t sel;
        if (rem_ge3)
            sel = STEP3;
        else if (rem_is2)
            sel = STEP2;
        else
            sel = STEP1;
        return sel;
    endfunction

    // Number of positions a given step code moves the shift register.
    function automatic logic [1:0] step_size(input step_sel_t sel);
        logic [1:0] size;
        unique case (sel)
            STEP3:   size = 2'd3;
            STEP2:   size = 2'd2;
            default: size = 2'd1;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/shift_step_ctrl.sv
// Multicycle shift sequencer. Accepts one shift request (kind + amount),
// drives a LOAD cycle, then steps the shift register by 3/2/1 positions
// per cycle until the amount is exhausted, and ends with a one-cycle done.
// Outputs decode from registered state only, so there is no path from
// start/op/shamt to any output.
module shift_step_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] shamt,
    output logic [1:0]       step_sel,
    output logic [2:0]       shift_cmd,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [1:0]       op_q;

    step_sel_t        step;
    logic [AMT_W-1:0] step_amt;
    logic             rem_ge3;
    logic             rem_is2;

    // Step that applies in the current SHIFT cycle, derived from the counter.
    assign rem_ge3  = (remaining >= AMT_W'(3));
    assign rem_is2  = (remaining == AMT_W'(2));
    assign step     = select_step(rem_ge3, rem_is2);
    assign step_amt = AMT_W'(step_size(step));

    // Sequencer FSM and down-counter; reset aborts any request with no done pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and ordering between statements does not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            op_q      <= 2'b00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        remaining <= shamt;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= (remaining != '0) ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    // The step never exceeds remaining, so this cannot underflow.
                    remaining <= remaining - step_amt;
                    state     <= (remaining == step_amt) ? ST_DONE : ST_SHIFT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from state, op_q and remaining only.
    // NOTE: every output gets a default before the case so no path through
    // the block leaves one unassigned, which would infer a latch.
    always_comb begin
        step_sel  = STEP1;
        shift_cmd = CMD_HOLD;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                shift_cmd = CMD_LOAD;
            end
            ST_SHIFT: begin
                shift_cmd = op_to_cmd(op_q);
                step_sel  = step;
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_step_ctrl.sv
// Directed testbench for shift_step_ctrl. Each scenario task drives one
// request pattern and compares the observed per-cycle outputs against
// hand-computed sequences.
module tb_shift_step_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [4:0] shamt;
    logic [1:0] step_sel;
    logic [2:0] shift_cmd;
    logic       busy;
    logic       done;

    int tests_run;
    int tests_failed;

    // Per-cycle record of one request, index 0 is the cycle after E0.
    logic [1:0] rec_step [0:63];
    logic [2:0] rec_cmd  [0:63];
    logic       rec_busy [0:63];
    logic       rec_done [0:63];
    int         rec_n;
    logic       rec_timeout;
    logic       idle_busy;
    logic       idle_done;

    shift_step_ctrl #(.AMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .shamt     (shamt),
        .step_sel  (step_sel),
        .shift_cmd (shift_cmd),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_val(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 100;
        endcase
    endfunction

    // Issue a one-cycle start from an IDLE cycle and record outputs until done,
    // then step once more into the following IDLE cycle.
    task automatic issue_and_record(input logic [1:0] o, input logic [4:0] a);
        start = 1'b1;
        op    = o;
        shamt = a;
        rec_n = 0;
        rec_timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rec_busy[rec_n] = busy;
            rec_done[rec_n] = done;
            rec_cmd[rec_n]  = shift_cmd;
            rec_step[rec_n] = step_sel;
            rec_n++;
            if (done) begin
                rec_timeout = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        idle_busy = busy;
        idle_done = done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        shamt = '0;
        #2;
        tests_run++;
        if ({step_sel, shift_cmd, busy, done} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got step=%b cmd=%b busy=%b done=%b, want 00 000 0 0",
                     step_sel, shift_cmd, busy, done);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({step_sel, shift_cmd, busy, done} !== 7'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got step=%b cmd=%b busy=%b done=%b, want 00 000 0 0",
                     step_sel, shift_cmd, busy, done);
        end
    endtask

    task automatic test_shamt7;
        logic [1:0] exp_step [0:2];
        int busy_cnt;
        exp_step = '{2'b10, 2'b10, 2'b00};
        issue_and_record(2'b00, 5'd7);
        tests_run++;
        if (rec_timeout || rec_n != 5) begin
            tests_failed++;
            $display("FAIL s7_done_edge: done after %0d edges (timeout=%b), want 4", rec_n - 1, rec_timeout);
        end
        tests_run++;
        if (rec_cmd[0] !== 3'b001 || rec_step[0] !== 2'b00) begin
            tests_failed++;
            $display("FAIL s7_load: got cmd=%b step=%b, want 001 00", rec_cmd[0], rec_step[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rec_cmd[1+i] !== 3'b010 || rec_step[1+i] !== exp_step[i]) begin
                tests_failed++;
                $display("FAIL s7_shift%0d: got cmd=%b step=%b, want 010 %b",
                         i, rec_cmd[1+i], rec_step[1+i], exp_step[i]);
            end
        end
        tests_run++;
        if (rec_done[4] !== 1'b1 || rec_cmd[4] !== 3'b000 || idle_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL s7_done_pulse: got done=%b cmd=%b next_done=%b, want 1 000 0",
                     rec_done[4], rec_cmd[4], idle_done);
        end
        busy_cnt = 0;
        for (int i = 0; i < rec_n; i++) if (rec_busy[i] === 1'b1) busy_cnt++;
        if (idle_busy === 1'b1) busy_cnt++;
        tests_run++;
        if (busy_cnt != 5) begin
            tests_failed++;
            $display("FAIL s7_busy_cycles: got %0d, want 5", busy_cnt);
        end
    endtask

    task automatic test_shamt0;
        int shift_cycles;
        issue_and_record(2'b10, 5'd0);
        tests_run++;
        if (rec_timeout || rec_n != 2 || rec_cmd[0] !== 3'b001) begin
            tests_failed++;
            $display("FAIL s0_sequence: done after %0d edges first_cmd=%b, want 1 edge cmd 001",
                     rec_n - 1, rec_cmd[0]);
        end
        shift_cycles = 0;
        for (int i = 0; i < rec_n; i++)
            if (rec_cmd[i] inside {3'b010, 3'b011, 3'b100, 3'b101}) shift_cycles++;
        tests_run++;
        if (shift_cycles != 0 || idle_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL s0_no_shift: got %0d shift cycles idle_busy=%b, want 0 0", shift_cycles, idle_busy);
        end
    endtask

    task automatic test_shamt31;
        int sum;
        int bad;
        issue_and_record(2'b11, 5'd31);
        tests_run++;
        if (rec_timeout || rec_n != 13 || idle_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL s31_busy_cycles: got %0d (timeout=%b), want 13", rec_n, rec_timeout);
        end
        sum = 0;
        bad = 0;
        for (int i = 1; i <= 11; i++) begin
            sum += step_val(rec_step[i]);
            if (rec_cmd[i] !== 3'b101) bad++;
            if (i <= 10 && rec_step[i] !== 2'b10) bad++;
            if (i == 11 && rec_step[i] !== 2'b00) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL s31_steps: got %0d mismatching shift cycles, want 0", bad);
        end
        tests_run++;
        if (sum != 31) begin
            tests_failed++;
            $display("FAIL s31_step_sum: got %0d, want 31", sum);
        end
    endtask

    task automatic test_start_held;
        logic       e_busy [0:8];
        logic       e_done [0:8];
        logic [2:0] e_cmd  [0:8];
        logic [1:0] e_step [0:8];
        e_busy = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
        e_done = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        e_cmd  = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b001, 3'b011, 3'b011, 3'b000, 3'b000};
        e_step = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
        start = 1'b1;
        op    = 2'b01;
        shamt = 5'd2;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i == 1) shamt = 5'd5;
            if (i == 4) start = 1'b0;
            tests_run++;
            if (busy !== e_busy[i] || done !== e_done[i] || shift_cmd !== e_cmd[i] || step_sel !== e_step[i]) begin
                tests_failed++;
                $display("FAIL held_cycle%0d: got busy=%b done=%b cmd=%b step=%b, want %b %b %b %b",
                         i, busy, done, shift_cmd, step_sel, e_busy[i], e_done[i], e_cmd[i], e_step[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int done_seen;
        start = 1'b1;
        op    = 2'b00;
        shamt = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (shift_cmd !== 3'b010 || step_sel !== 2'b10 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_shift2: got cmd=%b step=%b busy=%b, want 010 10 1", shift_cmd, step_sel, busy);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({step_sel, shift_cmd, busy, done} !== 7'b0) begin
            tests_failed++;
            $display("FAIL rst_async: got step=%b cmd=%b busy=%b done=%b, want 00 000 0 0",
                     step_sel, shift_cmd, busy, done);
        end
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL rst_no_done: got %0d done cycles, want 0", done_seen);
        end
        issue_and_record(2'b00, 5'd4);
        tests_run++;
        if (rec_timeout || rec_n != 4 || rec_step[1] !== 2'b10 || rec_step[2] !== 2'b00
            || rec_cmd[1] !== 3'b010 || rec_cmd[2] !== 3'b010) begin
            tests_failed++;
            $display("FAIL rst_fresh_s4: got n=%0d steps=%b,%b cmds=%b,%b, want 4 10,00 010,010",
                     rec_n, rec_step[1], rec_step[2], rec_cmd[1], rec_cmd[2]);
        end
    endtask

    task automatic test_back_to_back;
        issue_and_record(2'b00, 5'd1);
        tests_run++;
        if (rec_timeout || rec_n != 3 || rec_step[1] !== 2'b00 || rec_cmd[1] !== 3'b010
            || rec_done[1] !== 1'b0 || idle_done !== 1'b0 || idle_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: got n=%0d step=%b cmd=%b idle_done=%b idle_busy=%b, want 3 00 010 0 0",
                     rec_n, rec_step[1], rec_cmd[1], idle_done, idle_busy);
        end
        issue_and_record(2'b00, 5'd3);
        tests_run++;
        if (rec_timeout || rec_n != 3 || rec_step[1] !== 2'b10 || rec_cmd[1] !== 3'b010
            || rec_done[1] !== 1'b0 || idle_done !== 1'b0 || idle_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: got n=%0d step=%b cmd=%b idle_done=%b idle_busy=%b, want 3 10 010 0 0",
                     rec_n, rec_step[1], rec_cmd[1], idle_done, idle_busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_shamt7();
        test_shamt0();
        test_shamt31();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
